// File: rtl/jtag_pkg.sv
// Shared TAP definitions: exported state encoding, next-state function and the
// decoded-instruction type.
package jtag_pkg;

    typedef enum logic [3:0] {
        TapEx2Dr   = 4'h0,
        TapEx1Dr   = 4'h1,
        TapShDr    = 4'h2,
        TapPauseDr = 4'h3,
        TapSelIr   = 4'h4,
        TapUpdDr   = 4'h5,
        TapCapDr   = 4'h6,
        TapSelDr   = 4'h7,
        TapEx2Ir   = 4'h8,
        TapEx1Ir   = 4'h9,
        TapShIr    = 4'hA,
        TapPauseIr = 4'hB,
        TapRti     = 4'hC,
        TapUpdIr   = 4'hD,
        TapCapIr   = 4'hE,
        TapTlr     = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        Byp,
        Idc,
        Usr
    } instr_e;

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        tap_state_e n;
        n = TapTlr;
        case (s)
            TapTlr:     n = tms ? TapTlr   : TapRti;
            TapRti:     n = tms ? TapSelDr : TapRti;
            TapSelDr:   n = tms ? TapSelIr : TapCapDr;
            TapSelIr:   n = tms ? TapTlr   : TapCapIr;
            TapCapDr:   n = tms ? TapEx1Dr : TapShDr;
            TapShDr:    n = tms ? TapEx1Dr : TapShDr;
            TapEx1Dr:   n = tms ? TapUpdDr : TapPauseDr;
            TapPauseDr: n = tms ? TapEx2Dr : TapPauseDr;
            TapEx2Dr:   n = tms ? TapUpdDr : TapShDr;
            TapUpdDr:   n = tms ? TapSelDr : TapRti;
            TapCapIr:   n = tms ? TapEx1Ir : TapShIr;
            TapShIr:    n = tms ? TapEx1Ir : TapShIr;
            TapEx1Ir:   n = tms ? TapUpdIr : TapPauseIr;
            TapPauseIr: n = tms ? TapEx2Ir : TapPauseIr;
            TapEx2Ir:   n = tms ? TapUpdIr : TapShIr;
            TapUpdIr:   n = tms ? TapSelDr : TapRti;
            default:    n = TapTlr;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap_core_if.sv
// Serial JTAG pin bundle between the pad wrapper (master) and the TAP (slave).
interface jtag_tap_core_if;

    logic tms;
    logic tdi;
    logic tdo;
    logic tdo_en;

    modport master (
        output tms,
        output tdi,
        input  tdo,
        input  tdo_en
    );

    modport slave (
        input  tms,
        input  tdi,
        output tdo,
        output tdo_en
    );

endinterface

// File: rtl/jtag_shift_reg.sv
// Capture/shift register: parallel load on capture, LSB-first shift with tdi
// entering the MSB; holds otherwise.
module jtag_shift_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic             shift,
    input  logic [WIDTH-1:0] capture_val,
    input  logic             tdi,
    output logic [WIDTH-1:0] value,
    output logic             tdo
);

    logic [WIDTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (capture) begin
            sr_d = capture_val;
        end else if (shift) begin
            for (int i = 0; i < int'(WIDTH) - 1; i++) begin
                sr_d[i] = sr_q[i+1];
            end
            sr_d[WIDTH-1] = tdi;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign value = sr_q;
    assign tdo   = sr_q[0];

endmodule

// File: rtl/jtag_tap_core.sv
// IEEE 1149.1-style TAP: 16-state FSM, instruction register, and BYPASS /
// IDCODE / user data registers behind one serial TDI/TDO path.
module jtag_tap_core
    import jtag_pkg::*;
#(
    parameter int unsigned        IR_W       = 4,
    parameter int unsigned        USER_DR_W  = 8,
    parameter logic [31:0]        IDCODE_VAL = 32'h1234_5001,
    parameter logic [IR_W-1:0]    IR_IDCODE  = 4'b0001,
    parameter logic [IR_W-1:0]    IR_USER    = 4'b0010
) (
    input  logic                 tclk,
    input  logic                 trst,
    jtag_tap_core_if.slave       jtag,
    output logic [3:0]           state,
    output logic [IR_W-1:0]      ir,
    input  logic [USER_DR_W-1:0] user_dr_in,
    output logic [USER_DR_W-1:0] user_dr_out,
    output logic                 user_upd
);

    localparam int unsigned DR_W = (USER_DR_W > 32) ? USER_DR_W : 32;

    tap_state_e           state_q, state_d;
    logic [IR_W-1:0]      ir_q;
    logic [IR_W-1:0]      ir_sr;
    logic                 ir_tdo;
    logic [DR_W-1:0]      dr_sr_q, dr_sr_d;
    logic                 bypass_q, bypass_d;
    logic [USER_DR_W-1:0] user_dr_out_q;
    logic                 user_upd_q;
    logic                 user_upd_d;
    instr_e               dec;

    jtag_shift_reg #(
        .WIDTH (IR_W)
    ) u_ir_sr (
        .clk         (tclk),
        .rst_n       (trst),
        .capture     (state_q == TapCapIr),
        .shift       (state_q == TapShIr),
        .capture_val (IR_W'(2'b01)),
        .tdi         (jtag.tdi),
        .value       (ir_sr),
        .tdo         (ir_tdo)
    );

    // All-ones is BYPASS even if a parameter happens to alias it.
    always_comb begin
        dec = Byp;
        if (ir_q != '1) begin
            if (ir_q == IR_IDCODE) begin
                dec = Idc;
            end else if (ir_q == IR_USER) begin
                dec = Usr;
            end
        end
    end

    always_comb begin
        state_d    = tap_next(state_q, jtag.tms);
        dr_sr_d    = dr_sr_q;
        bypass_d   = bypass_q;
        user_upd_d = (state_q == TapUpdDr) && (dec == Usr);
        case (state_q)
            TapCapDr: begin
                case (dec)
                    Idc:     dr_sr_d = DR_W'(IDCODE_VAL);
                    Usr:     dr_sr_d[USER_DR_W-1:0] = user_dr_in;
                    default: bypass_d = 1'b0;
                endcase
            end
            TapShDr: begin
                case (dec)
                    Idc: begin
                        for (int i = 0; i < 31; i++) begin
                            dr_sr_d[i] = dr_sr_q[i+1];
                        end
                        dr_sr_d[31] = jtag.tdi;
                    end
                    Usr: begin
                        for (int i = 0; i < int'(USER_DR_W) - 1; i++) begin
                            dr_sr_d[i] = dr_sr_q[i+1];
                        end
                        dr_sr_d[USER_DR_W-1] = jtag.tdi;
                    end
                    default: bypass_d = jtag.tdi;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge tclk) begin
        if (!trst) begin
            state_q       <= TapTlr;
            ir_q          <= IR_IDCODE;
            dr_sr_q       <= '0;
            bypass_q      <= 1'b0;
            user_dr_out_q <= '0;
            user_upd_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dr_sr_q    <= dr_sr_d;
            bypass_q   <= bypass_d;
            user_upd_q <= user_upd_d;
            if (state_q == TapTlr) begin
                ir_q <= IR_IDCODE;
            end else if (state_q == TapUpdIr) begin
                ir_q <= ir_sr;
            end
            if (user_upd_d) begin
                user_dr_out_q <= dr_sr_q[USER_DR_W-1:0];
            end
        end
    end

    always_comb begin
        jtag.tdo = 1'b0;
        case (state_q)
            TapShIr: jtag.tdo = ir_tdo;
            TapShDr: jtag.tdo = (dec == Byp) ? bypass_q : dr_sr_q[0];
            default: ;
        endcase
    end

    assign jtag.tdo_en = (state_q == TapShDr) || (state_q == TapShIr);
    assign state       = state_q;
    assign ir          = ir_q;
    assign user_dr_out = user_dr_out_q;
    assign user_upd    = user_upd_q;

endmodule

// File: tb/tb_jtag_tap_core.sv
// Bench for jtag_tap_core: hand-computed vector table, directed scans, and a
// randomized run checked against a transition-table/arithmetic reference model.
module tb_jtag_tap_core;

    localparam int unsigned IR_W       = 4;
    localparam int unsigned USER_DR_W  = 8;
    localparam logic [31:0] IDCODE_VAL = 32'h1234_5001;
    localparam logic [3:0]  IR_IDCODE  = 4'b0001;
    localparam logic [3:0]  IR_USER    = 4'b0010;

    logic                 tclk = 1'b0;
    logic                 trst;
    logic [3:0]           state;
    logic [IR_W-1:0]      ir;
    logic [USER_DR_W-1:0] user_dr_in;
    logic [USER_DR_W-1:0] user_dr_out;
    logic                 user_upd;

    jtag_tap_core_if bus ();

    jtag_tap_core #(
        .IR_W       (IR_W),
        .USER_DR_W  (USER_DR_W),
        .IDCODE_VAL (IDCODE_VAL),
        .IR_IDCODE  (IR_IDCODE),
        .IR_USER    (IR_USER)
    ) dut (
        .tclk        (tclk),
        .trst        (trst),
        .jtag        (bus.slave),
        .state       (state),
        .ir          (ir),
        .user_dr_in  (user_dr_in),
        .user_dr_out (user_dr_out),
        .user_upd    (user_upd)
    );

    always #5 tclk = ~tclk;

    int checks = 0;
    int errors = 0;
    bit mcheck = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: 1149.1 transition table plus arithmetic on register values.
    logic [3:0]      nxt0 [16];
    logic [3:0]      nxt1 [16];
    logic [3:0]      m_state;
    logic [IR_W-1:0] m_ir, m_irsr;
    logic [63:0]     m_dr;
    logic            m_byp;
    logic [7:0]      m_uout;
    logic            m_upd;

    task automatic init_table();
        nxt0[4'hF] = 4'hC; nxt1[4'hF] = 4'hF;
        nxt0[4'hC] = 4'hC; nxt1[4'hC] = 4'h7;
        nxt0[4'h7] = 4'h6; nxt1[4'h7] = 4'h4;
        nxt0[4'h4] = 4'hE; nxt1[4'h4] = 4'hF;
        nxt0[4'h6] = 4'h2; nxt1[4'h6] = 4'h1;
        nxt0[4'h2] = 4'h2; nxt1[4'h2] = 4'h1;
        nxt0[4'h1] = 4'h3; nxt1[4'h1] = 4'h5;
        nxt0[4'h3] = 4'h3; nxt1[4'h3] = 4'h0;
        nxt0[4'h0] = 4'h2; nxt1[4'h0] = 4'h5;
        nxt0[4'h5] = 4'hC; nxt1[4'h5] = 4'h7;
        nxt0[4'hE] = 4'hA; nxt1[4'hE] = 4'h9;
        nxt0[4'hA] = 4'hA; nxt1[4'hA] = 4'h9;
        nxt0[4'h9] = 4'hB; nxt1[4'h9] = 4'hD;
        nxt0[4'hB] = 4'hB; nxt1[4'hB] = 4'h8;
        nxt0[4'h8] = 4'hA; nxt1[4'h8] = 4'hD;
        nxt0[4'hD] = 4'hC; nxt1[4'hD] = 4'h7;
    endtask

    function automatic int m_dec();
        if (m_ir == 4'hF) return 0;
        if (m_ir == IR_IDCODE) return 1;
        if (m_ir == IR_USER) return 2;
        return 0;
    endfunction

    function automatic logic m_tdo();
        if (m_state == 4'hA) return m_irsr[0];
        if (m_state == 4'h2) return (m_dec() == 0) ? m_byp : m_dr[0];
        return 1'b0;
    endfunction

    task automatic model_edge(input logic t_tms, input logic t_tdi, input logic t_trst,
                              input logic [7:0] din);
        int          d;
        int          len;
        logic [63:0] mask;
        d = m_dec();
        if (!t_trst) begin
            m_state = 4'hF; m_ir = IR_IDCODE; m_irsr = '0; m_dr = '0;
            m_byp = 1'b0; m_uout = '0; m_upd = 1'b0;
            return;
        end
        m_upd = 1'b0;
        case (m_state)
            4'hF: m_ir = IR_IDCODE;
            4'hE: m_irsr = 4'd1;
            4'hA: m_irsr = (m_irsr >> 1) | (IR_W'(t_tdi) << (IR_W - 1));
            4'hD: m_ir = m_irsr;
            4'h6: begin
                if (d == 0) m_byp = 1'b0;
                else if (d == 1) m_dr = 64'(IDCODE_VAL);
                else m_dr = (m_dr & ~64'hFF) | 64'(din);
            end
            4'h2: begin
                if (d == 0) begin
                    m_byp = t_tdi;
                end else begin
                    len  = (d == 1) ? 32 : USER_DR_W;
                    mask = (64'd1 << len) - 64'd1;
                    m_dr = (m_dr & ~mask) | ((m_dr & mask) >> 1) | (64'(t_tdi) << (len - 1));
                end
            end
            4'h5: if (d == 2) begin m_uout = m_dr[7:0]; m_upd = 1'b1; end
            default: ;
        endcase
        m_state = t_tms ? nxt1[m_state] : nxt0[m_state];
    endtask

    task automatic compare_model();
        chk("m_state", 64'(state), 64'(m_state));
        chk("m_ir", 64'(ir), 64'(m_ir));
        chk("m_tdo", 64'(bus.tdo), 64'(m_tdo()));
        chk("m_tdo_en", 64'(bus.tdo_en), 64'((m_state == 4'h2) || (m_state == 4'hA)));
        chk("m_user_dr_out", 64'(user_dr_out), 64'(m_uout));
        chk("m_user_upd", 64'(user_upd), 64'(m_upd));
    endtask

    // Inputs change at the falling edge; outputs are compared there too.
    task automatic tick(input logic t_tms, input logic t_tdi, input logic t_trst);
        bus.tms = t_tms;
        bus.tdi = t_tdi;
        trst    = t_trst;
        @(posedge tclk);
        model_edge(t_tms, t_tdi, t_trst, user_dr_in);
        @(negedge tclk);
        if (mcheck) compare_model();
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0);
    endtask

    task automatic go_rti();
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
    endtask

    // From TLR or RTI; ends in RTI.
    task automatic load_ir(input logic [IR_W-1:0] op);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < int'(IR_W); i++) tick(i == int'(IR_W) - 1, op[i], 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
    endtask

    // From RTI; ends in RTI one edge after Update-DR.
    task automatic scan_dr(input logic [63:0] din, input int len, output logic [63:0] dout);
        dout = '0;
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < len; i++) begin
            dout[i] = bus.tdo;
            tick(i == len - 1, din[i], 1'b1);
        end
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
    endtask

    typedef struct {
        logic       tms;
        logic       tdi;
        logic [3:0] st;
        logic       tdo;
        logic       en;
        logic [3:0] ir;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [63:0] dout;
        logic [3:0]  walk [5];
        logic [3:0]  op;
        int          r;

        init_table();
        bus.tms    = 1'b1;
        bus.tdi    = 1'b0;
        trst       = 1'b0;
        user_dr_in = '0;
        @(negedge tclk);

        do_reset();
        chk("rst_state", 64'(state), 64'hF);
        chk("rst_ir", 64'(ir), 64'(IR_IDCODE));
        chk("rst_tdo_en", 64'(bus.tdo_en), 64'h0);
        chk("rst_user_dr_out", 64'(user_dr_out), 64'h0);
        chk("rst_user_upd", 64'(user_upd), 64'h0);

        // IR scan of 4'b1111 then a 3-bit bypass scan, values worked out by hand.
        vecs.push_back('{1'b0, 1'b0, 4'hC, 1'b0, 1'b0, 4'h1});
        vecs.push_back('{1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 4'h1});
        vecs.push_back('{1'b1, 1'b0, 4'h4, 1'b0, 1'b0, 4'h1});
        vecs.push_back('{1'b0, 1'b0, 4'hE, 1'b0, 1'b0, 4'h1});
        vecs.push_back('{1'b0, 1'b0, 4'hA, 1'b1, 1'b1, 4'h1});
        vecs.push_back('{1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 4'h1});
        vecs.push_back('{1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 4'h1});
        vecs.push_back('{1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 4'h1});
        vecs.push_back('{1'b1, 1'b1, 4'h9, 1'b0, 1'b0, 4'h1});
        vecs.push_back('{1'b1, 1'b0, 4'hD, 1'b0, 1'b0, 4'h1});
        vecs.push_back('{1'b0, 1'b0, 4'hC, 1'b0, 1'b0, 4'hF});
        vecs.push_back('{1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 4'hF});
        vecs.push_back('{1'b0, 1'b0, 4'h6, 1'b0, 1'b0, 4'hF});
        vecs.push_back('{1'b0, 1'b0, 4'h2, 1'b0, 1'b1, 4'hF});
        vecs.push_back('{1'b0, 1'b1, 4'h2, 1'b1, 1'b1, 4'hF});
        vecs.push_back('{1'b0, 1'b0, 4'h2, 1'b0, 1'b1, 4'hF});
        vecs.push_back('{1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 4'hF});
        vecs.push_back('{1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 4'hF});
        vecs.push_back('{1'b0, 1'b0, 4'hC, 1'b0, 1'b0, 4'hF});
        foreach (vecs[i]) begin
            tick(vecs[i].tms, vecs[i].tdi, 1'b1);
            chk($sformatf("vec%0d_state", i), 64'(state), 64'(vecs[i].st));
            chk($sformatf("vec%0d_tdo", i), 64'(bus.tdo), 64'(vecs[i].tdo));
            chk($sformatf("vec%0d_tdo_en", i), 64'(bus.tdo_en), 64'(vecs[i].en));
            chk($sformatf("vec%0d_ir", i), 64'(ir), 64'(vecs[i].ir));
        end

        // IDCODE read-out, LSB first.
        do_reset();
        tick(1'b0, 1'b0, 1'b1);
        scan_dr(64'h0, 32, dout);
        chk("idcode", dout[31:0], 64'(IDCODE_VAL));

        // User DR capture/shift/update and persistence through TMS-driven TLR.
        do_reset();
        load_ir(IR_USER);
        chk("user_ir", 64'(ir), 64'(IR_USER));
        user_dr_in = 8'hA5;
        scan_dr(64'h3C, 8, dout);
        chk("user_capture", dout[7:0], 64'hA5);
        chk("user_dr_out", 64'(user_dr_out), 64'h3C);
        chk("user_upd_hi", 64'(user_upd), 64'h1);
        tick(1'b0, 1'b0, 1'b1);
        chk("user_upd_lo", 64'(user_upd), 64'h0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b1);
        chk("tlr_state", 64'(state), 64'hF);
        chk("tlr_keeps_user_out", 64'(user_dr_out), 64'h3C);
        chk("tlr_ir", 64'(ir), 64'(IR_IDCODE));

        // TRST from Shift-DR wins over TMS and clears USER_DR_OUT.
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        chk("pre_trst_state", 64'(state), 64'h2);
        tick(1'b1, 1'b0, 1'b0);
        chk("trst_state", 64'(state), 64'hF);
        chk("trst_ir", 64'(ir), 64'(IR_IDCODE));
        chk("trst_tdo_en", 64'(bus.tdo_en), 64'h0);
        chk("trst_user_dr_out", 64'(user_dr_out), 64'h0);

        // Five TMS=1 edges from Shift-IR.
        walk[0] = 4'h9; walk[1] = 4'hD; walk[2] = 4'h7; walk[3] = 4'h4; walk[4] = 4'hF;
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        chk("walk_start", 64'(state), 64'hA);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            chk($sformatf("walk%0d", i), 64'(state), 64'(walk[i]));
        end

        // Undefined opcode decodes to BYPASS.
        do_reset();
        load_ir(4'b0111);
        chk("undef_ir", 64'(ir), 64'h7);
        scan_dr(64'b011, 3, dout);
        chk("undef_bypass", dout[2:0], 64'b110);

        // Randomized run, every edge compared against the model.
        mcheck = 1;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                go_rti();
                case ($urandom_range(0, 2))
                    0:       op = IR_IDCODE;
                    1:       op = IR_USER;
                    default: op = 4'($urandom);
                endcase
                load_ir(op);
            end else if (r < 5) begin
                go_rti();
                user_dr_in = 8'($urandom);
                scan_dr({$urandom, $urandom}, $urandom_range(1, 40), dout);
            end else begin
                for (int k = 0; k < 8; k++) begin
                    user_dr_in = 8'($urandom);
                    tick(1'($urandom), 1'($urandom), $urandom_range(0, 40) != 0);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
